// File: rtl/fixed_divider.sv
// fixed_divider: sequential signed fixed-point divider with saturation and divide-by-zero flag
module fixed_divider #(
  parameter int WI1 = 2,
  parameter int WF1 = 6,
  parameter int WI2 = 2,
  parameter int WF2 = 6,
  parameter int WIO = 2,
  parameter int WFO = 6
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 start,
  input  logic [WI1+WF1-1:0]   in1,
  input  logic [WI2+WF2-1:0]   in2,
  output logic                 busy,
  output logic                 done,
  output logic [WIO+WFO-1:0]   outDiv,
  output logic                 OVF,
  output logic                 DBZ
);
  localparam int W1 = WI1 + WF1;
  localparam int W2 = WI2 + WF2;
  localparam int WE = WI1 + WFO + WF2;
  localparam int WO = WIO + WFO;
  localparam int SH = WFO + WF2 - WF1;
  localparam int CW = $clog2(WE + 1);
  localparam int MW = (WE > WO ? WE : WO) + 1;
  localparam logic [MW-1:0] LIM = MW'(1) << (WO - 1);
  localparam logic [WO-1:0] MAXP = {1'b0, {(WO-1){1'b1}}};
  localparam logic [WO-1:0] MINN = {1'b1, {(WO-1){1'b0}}};
  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
  state_t st;
  logic [WE-1:0] a;
  logic [W2-1:0] b, r;
  logic [CW-1:0] cnt;
  logic neg, s1, z;
  logic [W1-1:0] m1;
  logic [W2-1:0] m2;
  logic [W2:0] rs;
  logic ge, pos_ovf, neg_ovf, ovf;
  logic [MW-1:0] mx;
  logic [WO-1:0] res;
  // operand magnitudes, one restoring-division step, and the saturated signed result
  always_comb begin
    m1 = in1[W1-1] ? -in1 : in1;
    m2 = in2[W2-1] ? -in2 : in2;
    rs = {r, a[WE-1]};
    ge = rs >= {1'b0, b};
    mx = MW'(a);
    pos_ovf = mx > LIM - MW'(1);
    neg_ovf = mx > LIM;
    res = z ? (s1 ? MINN : MAXP) : neg ? (neg_ovf ? MINN : -mx[WO-1:0]) : (pos_ovf ? MAXP : mx[WO-1:0]);
    ovf = z | (neg ? neg_ovf : pos_ovf);
  end
  // control FSM; the dividend register shifts out dividend bits and shifts in quotient bits
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      st <= IDLE;
      a <= '0;
      b <= '0;
      r <= '0;
      cnt <= '0;
      neg <= 1'b0;
      s1 <= 1'b0;
      z <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      outDiv <= '0;
      OVF <= 1'b0;
      DBZ <= 1'b0;
    end else begin
      done <= 1'b0;
      case (st)
        IDLE: if (start) begin
          a <= WE'(m1) << SH;
          b <= m2;
          r <= '0;
          cnt <= CW'(WE - 1);
          s1 <= in1[W1-1];
          neg <= in1[W1-1] ^ in2[W2-1];
          z <= in2 == '0;
          busy <= 1'b1;
          st <= in2 == '0 ? FIX : CALC;
        end
        CALC: begin
          a <= {a[WE-2:0], ge};
          r <= ge ? W2'(rs - {1'b0, b}) : rs[W2-1:0];
          cnt <= cnt - CW'(1);
          if (cnt == '0) st <= FIX;
        end
        FIX: begin
          outDiv <= res;
          OVF <= ovf;
          DBZ <= z;
          done <= 1'b1;
          busy <= 1'b0;
          st <= IDLE;
        end
        default: st <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fixed_divider.sv
// tb_fixed_divider: directed vector table plus corner-case sequences for fixed_divider
module tb_fixed_divider;
  logic CLK = 1'b0, RST = 1'b1, start = 1'b0;
  logic [7:0] in1 = '0, in2 = '0;
  logic busy, done, OVF, DBZ;
  logic [7:0] outDiv;
  int total = 0, bad = 0;
  typedef struct {logic [7:0] a, b, q; logic ovf, dbz; int lat;} vec_t;
  vec_t v[13];

  fixed_divider dut (.CLK(CLK), .RST(RST), .start(start), .in1(in1), .in2(in2),
                     .busy(busy), .done(done), .outDiv(outDiv), .OVF(OVF), .DBZ(DBZ));

  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic wait_done(input int l0, output int lat);
    lat = l0;
    while (!done && lat < 40) begin
      @(posedge CLK); #1;
      lat++;
    end
  endtask

  task automatic do_op(input logic [7:0] x, input logic [7:0] y, output int lat, output int bc);
    @(negedge CLK);
    in1 = x; in2 = y; start = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0;
    lat = 0;
    bc = int'(busy);
    while (!done && lat < 40) begin
      @(posedge CLK); #1;
      lat++;
      bc += int'(busy);
    end
  endtask

  initial begin
    int lat, bc, seen;
    v[0]  = '{8'h20, 8'h40, 8'h20, 1'b0, 1'b0, 15};
    v[1]  = '{8'hD0, 8'h20, 8'hA0, 1'b0, 1'b0, 15};
    v[2]  = '{8'h10, 8'h30, 8'h15, 1'b0, 1'b0, 15};
    v[3]  = '{8'h40, 8'h20, 8'h7F, 1'b1, 1'b0, 15};
    v[4]  = '{8'hC0, 8'h20, 8'h80, 1'b0, 1'b0, 15};
    v[5]  = '{8'h80, 8'hC0, 8'h7F, 1'b1, 1'b0, 15};
    v[6]  = '{8'h10, 8'h00, 8'h7F, 1'b1, 1'b1, 1};
    v[7]  = '{8'hF0, 8'h00, 8'h80, 1'b1, 1'b1, 1};
    v[8]  = '{8'h00, 8'hC0, 8'h00, 1'b0, 1'b0, 15};
    v[9]  = '{8'hE0, 8'hE0, 8'h40, 1'b0, 1'b0, 15};
    v[10] = '{8'h01, 8'hFF, 8'hC0, 1'b0, 1'b0, 15};
    v[11] = '{8'h7F, 8'h01, 8'h7F, 1'b1, 1'b0, 15};
    v[12] = '{8'h80, 8'h01, 8'h80, 1'b1, 1'b0, 15};
    #3 RST = 1'b0;
    #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_out", int'(outDiv), 0);
    chk("rst_ovf", int'(OVF), 0);
    chk("rst_dbz", int'(DBZ), 0);
    repeat (2) @(negedge CLK);
    RST = 1'b1;
    for (int i = 0; i < 13; i++) begin
      do_op(v[i].a, v[i].b, lat, bc);
      chk($sformatf("v%0d_lat", i), lat, v[i].lat);
      chk($sformatf("v%0d_busy", i), bc, v[i].lat);
      chk($sformatf("v%0d_out", i), int'(outDiv), int'(v[i].q));
      chk($sformatf("v%0d_ovf", i), int'(OVF), int'(v[i].ovf));
      chk($sformatf("v%0d_dbz", i), int'(DBZ), int'(v[i].dbz));
    end
    @(negedge CLK);
    in1 = 8'h20; in2 = 8'h40; start = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0;
    repeat (5) @(posedge CLK);
    #1;
    start = 1'b1; in1 = 8'h40; in2 = 8'h20;
    @(posedge CLK); #1;
    start = 1'b0; in1 = 8'hFF; in2 = 8'h00;
    wait_done(6, lat);
    chk("mid_lat", lat, 15);
    chk("mid_out", int'(outDiv), 8'h20);
    chk("mid_ovf", int'(OVF), 0);
    @(posedge CLK); #1;
    chk("mid_nobusy", int'(busy), 0);
    do_op(8'h10, 8'h30, lat, bc);
    chk("b2b_lat1", lat, 15);
    chk("b2b_out1", int'(outDiv), 8'h15);
    start = 1'b1; in1 = 8'hD0; in2 = 8'h20;
    @(posedge CLK); #1;
    start = 1'b0;
    chk("b2b_busy", int'(busy), 1);
    chk("b2b_hold", int'(outDiv), 8'h15);
    wait_done(0, lat);
    chk("b2b_lat2", lat, 15);
    chk("b2b_out2", int'(outDiv), 8'hA0);
    @(negedge CLK);
    in1 = 8'h20; in2 = 8'h40; start = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0;
    repeat (7) @(posedge CLK);
    #1 RST = 1'b0;
    #1;
    chk("arst_busy", int'(busy), 0);
    chk("arst_done", int'(done), 0);
    chk("arst_out", int'(outDiv), 0);
    chk("arst_ovf", int'(OVF), 0);
    chk("arst_dbz", int'(DBZ), 0);
    seen = 0;
    repeat (3) begin
      @(posedge CLK); #1;
      seen |= int'(done);
    end
    @(negedge CLK);
    RST = 1'b1;
    repeat (20) begin
      @(posedge CLK); #1;
      seen |= int'(done) | int'(busy);
    end
    chk("arst_nodone", seen, 0);
    do_op(8'hD0, 8'h20, lat, bc);
    chk("arst_lat", lat, 15);
    chk("arst_res", int'(outDiv), 8'hA0);
    chk("arst_resovf", int'(OVF), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fixed_divider.md
FIXED_DIVIDER -- requirements
Module: fixed_divider

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- WI1, 2, dividend integer bits (incl. sign)
- WF1, 6, dividend fraction bits
- WI2, 2, divisor integer bits (incl. sign)
- WF2, 6, divisor fraction bits
- WIO, 2, quotient integer bits (incl. sign)
- WFO, 6, quotient fraction bits
REQ-002 Parameters SHALL satisfy WFO+WF2 >= WF1 and WIO >= 1; other combinations are unsupported.
REQ-003 The block SHALL have these ports (name, direction, width, meaning):
- CLK  in  1  single clock; all state on rising edge
- RST  in  1  asynchronous, active-low reset
- start  in  1  request: latch operands and begin division
- in1  in  WI1+WF1  signed dividend
- in2  in  WI2+WF2  signed divisor
- busy  out  1  division in progress
- done  out  1  one-cycle pulse; result valid
- outDiv  out  WIO+WFO  signed quotient
- OVF  out  1  quotient saturated
- DBZ  out  1  divisor was zero

Function
REQ-004 Define WE = WI1+WFO+WF2 (extended dividend width) and WO = WIO+WFO.
REQ-005 The state machine SHALL have states IDLE, CALC, FIX.
REQ-006 In IDLE, start=1 at a rising edge SHALL latch in1, in2, their signs and magnitudes, set busy=1, and go to CALC; if in2=0, it SHALL go to FIX directly instead.
REQ-007 The operand magnitude of the most negative input (e.g. 0x80) SHALL be 2^(n-1), held unsigned without loss.
REQ-008 The extended dividend SHALL be |in1| shifted left by WFO+WF2-WF1 bits.
REQ-009 CALC SHALL perform unsigned restoring division, one quotient bit per cycle, MSB first, using a down-counter; it SHALL spend exactly WE cycles, then go to FIX.
REQ-010 The quotient magnitude SHALL be truncated toward zero; no rounding.
REQ-011 The result sign SHALL be sign(in1) XOR sign(in2); a zero quotient SHALL output 0 regardless of sign.
REQ-012 If the sign is positive and magnitude > 2^(WO-1)-1, outDiv SHALL be 2^(WO-1)-1 with OVF=1.
REQ-013 If the sign is negative and magnitude > 2^(WO-1), outDiv SHALL be -2^(WO-1) with OVF=1; magnitude exactly 2^(WO-1) SHALL give -2^(WO-1) with OVF=0.
REQ-014 For divide-by-zero, FIX SHALL output max positive if in1 >= 0 or min negative if in1 < 0, with OVF=1 and DBZ=1.
REQ-015 FIX SHALL register outDiv, OVF and DBZ, pulse done=1 for exactly one cycle, clear busy, and return to IDLE.
REQ-016 Latency: normal done SHALL be asserted after the (WE+1)th edge following the start edge; divide-by-zero done SHALL be asserted after the 1st edge following it.
REQ-017 outDiv, OVF and DBZ SHALL hold until the next FIX.
REQ-018 start while busy=1 SHALL be ignored, and input changes during busy SHALL not affect the result.
REQ-019 start=1 in the cycle done=1 SHALL be accepted; back-to-back operation is allowed.

Reset
REQ-020 RST=0 SHALL asynchronously force state IDLE and busy, done, outDiv, OVF, DBZ and all internal registers to 0, including mid-CALC; the aborted division SHALL produce no done.
REQ-021 After RST rises, the first start SHALL behave per REQ-006.

Verification (default parameters: WE=14, Q2.6 formats)
REQ-022 in1=0x20 (0.5), in2=0x40 (1.0), start -> done after 15 edges; outDiv=0x20, OVF=0, DBZ=0; busy high for 15 cycles.
REQ-023 in1=0xD0 (-0.75), in2=0x20 (0.5) -> outDiv=0xA0 (-1.5), OVF=0; in1=0x10, in2=0x30 -> outDiv=0x15 (truncated 0.333).
REQ-024 in1=0x40, in2=0x20 -> outDiv=0x7F, OVF=1; in1=0xC0 (-1.0), in2=0x20 -> outDiv=0x80, OVF=0; in1=0x80, in2=0xC0 -> outDiv=0x7F, OVF=1.
REQ-025 in1=0x10, in2=0x00 -> done after 1 edge, outDiv=0x7F, OVF=1, DBZ=1; in1=0xF0, in2=0 -> outDiv=0x80, OVF=1, DBZ=1.
REQ-026 start pulsed again mid-CALC with new operands -> ignored, first result is correct; start held during the done cycle -> second result after 15 more edges.
REQ-027 RST=0 at CALC cycle 7 -> all outputs 0 immediately, no done pulse; a fresh start after release -> correct result.
